// File: rtl/rv_fpu_rsp_arb_pkg.sv
// Shared constants for the FPU response merge stage: lane width and fflags layout.
package rv_fpu_rsp_arb_pkg;

  localparam int XLEN        = 32;
  localparam int FFLAGS_BITS = 5;

  // Bit positions inside one lane's {NV,DZ,OF,UF,NX} group.
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

endpackage

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer,
// pointer advances past the winner only when the grant is taken (i_en).
module rv_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;
  int            w_j;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N; i++) begin
      w_j = (int'(r_ptr) + i) % N;
      if (!w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        w_grant[w_j]  = 1'b1;
        w_idx         = IW'(w_j);
      end
    end
  end

  assign o_grant = i_en ? w_grant : '0;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + IW'(1);
    end
  end

endmodule

// File: rtl/rv_fpu_rsp_arb.sv
// FPU response merge: round-robin pick among unit results into a small FIFO
// feeding commit. Payload passes through untouched except fflags zeroed when not valid.
module rv_fpu_rsp_arb
  import rv_fpu_rsp_arb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int LANES     = 2,
  parameter int TAGW      = 2,
  parameter int DEPTH     = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_UNITS-1:0]             i_valid_in,
  output logic [NUM_UNITS-1:0]             o_ready_in,
  input  logic [NUM_UNITS*LANES*XLEN-1:0]  i_result_in,
  input  logic [NUM_UNITS*TAGW-1:0]        i_tag_in,
  input  logic [NUM_UNITS-1:0]             i_has_ff_in,
  input  logic [NUM_UNITS*LANES*FFLAGS_BITS-1:0] i_fflags_in,
  output logic                             o_valid_out,
  input  logic                             i_ready_out,
  output logic [LANES*XLEN-1:0]            o_result,
  output logic [TAGW-1:0]                  o_tag_out,
  output logic                             o_has_fflags,
  output logic [LANES*FFLAGS_BITS-1:0]     o_fflags
);

  localparam int RW = LANES * XLEN;
  localparam int FW = LANES * FFLAGS_BITS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = $clog2(NUM_UNITS);

  logic [RW-1:0]   r_res   [DEPTH];
  logic [TAGW-1:0] r_tag   [DEPTH];
  logic            r_hasff [DEPTH];
  logic [FW-1:0]   r_ff    [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [NUM_UNITS-1:0] w_grant;
  logic [UW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_space;
  logic                 w_push;
  logic                 w_pop;
  logic [RW-1:0]        w_res;
  logic [TAGW-1:0]      w_tag;
  logic                 w_hasff;
  logic [FW-1:0]        w_ff;

  assign o_valid_out = (r_count != '0);
  assign w_pop       = o_valid_out & i_ready_out;
  // Reset also gates the grant so no unit sees an accept while state is being cleared.
  assign w_space     = ((r_count < CW'(DEPTH)) | w_pop) & ~i_reset;

  rv_rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_req   (i_valid_in),
    .i_en    (w_space),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign o_ready_in = w_grant;
  assign w_push     = w_any & w_space;

  assign w_res   = i_result_in[int'(w_idx)*RW +: RW];
  assign w_tag   = i_tag_in[int'(w_idx)*TAGW +: TAGW];
  assign w_hasff = i_has_ff_in[w_idx];
  assign w_ff    = w_hasff ? i_fflags_in[int'(w_idx)*FW +: FW] : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i]   <= '0;
        r_tag[i]   <= '0;
        r_hasff[i] <= 1'b0;
        r_ff[i]    <= '0;
      end
    end else begin
      if (w_push) begin
        r_res[r_wr_ptr]   <= w_res;
        r_tag[r_wr_ptr]   <= w_tag;
        r_hasff[r_wr_ptr] <= w_hasff;
        r_ff[r_wr_ptr]    <= w_ff;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_result     = r_res[r_rd_ptr];
  assign o_tag_out    = r_tag[r_rd_ptr];
  assign o_has_fflags = r_hasff[r_rd_ptr];
  assign o_fflags     = r_ff[r_rd_ptr];

endmodule

// File: tb/tb_rv_fpu_rsp_arb.sv
// Directed vector table plus hand sequences and a random scoreboard run for rv_fpu_rsp_arb.
module tb_rv_fpu_rsp_arb;

  logic         clk;
  logic         reset;
  logic [3:0]   valid_in;
  logic [3:0]   ready_in;
  logic [255:0] result_in;
  logic [7:0]   tag_in;
  logic [3:0]   has_ff_in;
  logic [39:0]  fflags_in;
  logic         valid_out;
  logic         ready_out;
  logic [63:0]  result;
  logic [1:0]   tag_out;
  logic         has_fflags;
  logic [9:0]   fflags;

  int ntests = 0;
  int nfail  = 0;

  rv_fpu_rsp_arb #(.NUM_UNITS(4), .LANES(2), .TAGW(2), .DEPTH(2)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_valid_in   (valid_in),
    .o_ready_in   (ready_in),
    .i_result_in  (result_in),
    .i_tag_in     (tag_in),
    .i_has_ff_in  (has_ff_in),
    .i_fflags_in  (fflags_in),
    .o_valid_out  (valid_out),
    .i_ready_out  (ready_out),
    .o_result     (result),
    .o_tag_out    (tag_out),
    .o_has_fflags (has_fflags),
    .o_fflags     (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic       ro;
    logic [3:0] er;
    logic       ev;
    logic [1:0] et;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [1:0]  tag;
    logic        hf;
    logic [9:0]  ff;
  } rsp_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard per-unit payload: tag=u, odd units carry fflags.
  function automatic logic [63:0] std_res(input int u);
    return {32'h2000_0000 + 32'(u), 32'h1000_0000 + 32'(u)};
  endfunction

  function automatic logic [9:0] std_ff(input int u);
    return 10'h2A0 | 10'(u);
  endfunction

  task automatic set_std_data();
    for (int u = 0; u < 4; u++) begin
      result_in[u*64 +: 64] = std_res(u);
      tag_in[u*2 +: 2]      = 2'(u);
      has_ff_in[u]          = u[0];
      fflags_in[u*10 +: 10] = std_ff(u);
    end
  endtask

  logic [63:0] u_res [4];
  logic [1:0]  u_tag [4];
  logic        u_hf  [4];
  logic [9:0]  u_ff  [4];
  logic        u_vld [4];
  logic [23:0] u_seq [4];
  rsp_t        q[$];
  rsp_t        e;
  rsp_t        h;
  logic [3:0]  acc;

  initial begin
    reset     = 1'b1;
    valid_in  = '0;
    ready_out = 1'b0;
    result_in = '0;
    tag_in    = '0;
    has_ff_in = '0;
    fflags_in = '0;
    set_std_data();

    vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0};
    vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1};
    vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2};
    vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd3};
    vecs[5]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0};
    vecs[6]  = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[7]  = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0};
    vecs[8]  = '{4'hF, 1'b0, 4'h4, 1'b1, 2'd1};
    vecs[9]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
    vecs[10] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
    vecs[11] = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd1};
    vecs[12] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd2};
    vecs[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3};
    vecs[14] = '{4'h8, 1'b0, 4'h8, 1'b0, 2'd0};
    vecs[15] = '{4'h9, 1'b0, 4'h1, 1'b1, 2'd3};
    vecs[16] = '{4'h8, 1'b1, 4'h8, 1'b1, 2'd3};
    vecs[17] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0};
    vecs[18] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3};
    vecs[19] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};

    @(negedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_ready_in",  64'(ready_in),  64'd0);
    chk("rst_result",    result,         64'd0);
    chk("rst_fflags",    64'(fflags),    64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid_in  = vecs[i].v;
      ready_out = vecs[i].ro;
      #1;
      chk($sformatf("vec%0d_ready_in", i),  64'(ready_in),  64'(vecs[i].er));
      chk($sformatf("vec%0d_valid_out", i), 64'(valid_out), 64'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_tag", i),    64'(tag_out), 64'(vecs[i].et));
        chk($sformatf("vec%0d_result", i), result, std_res(int'(vecs[i].et)));
        chk($sformatf("vec%0d_hasff", i),  64'(has_fflags), 64'(vecs[i].et[0]));
        chk($sformatf("vec%0d_fflags", i), 64'(fflags),
            vecs[i].et[0] ? 64'(std_ff(int'(vecs[i].et))) : 64'd0);
      end
    end

    // Pass-through with fflags forced to zero when has_ff is clear.
    @(negedge clk);
    result_in[2*64 +: 64] = {32'h4000_0000, 32'h3FC0_0000};
    tag_in[2*2 +: 2]      = 2'b10;
    has_ff_in[2]          = 1'b0;
    fflags_in[2*10 +: 10] = 10'h3FF;
    valid_in  = 4'b0100;
    ready_out = 1'b1;
    #1;
    chk("pt_ready_in", 64'(ready_in), 64'h4);
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk("pt_valid_out", 64'(valid_out), 64'd1);
    chk("pt_result",    result, {32'h4000_0000, 32'h3FC0_0000});
    chk("pt_tag",       64'(tag_out), 64'd2);
    chk("pt_hasff",     64'(has_fflags), 64'd0);
    chk("pt_fflags",    64'(fflags), 64'd0);
    set_std_data();

    // Reset with two entries queued, then a fresh single request.
    @(negedge clk);
    valid_in  = 4'hF;
    ready_out = 1'b0;
    #1;
    chk("rm_grant3", 64'(ready_in), 64'h8);
    @(negedge clk);
    #1;
    chk("rm_grant0", 64'(ready_in), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm_valid_out", 64'(valid_out), 64'd0);
    chk("rm_ready_in",  64'(ready_in),  64'd0);
    chk("rm_tag",       64'(tag_out),   64'd0);
    @(negedge clk);
    reset     = 1'b0;
    valid_in  = 4'b0010;
    ready_out = 1'b1;
    #1;
    chk("rm_after_ready_in", 64'(ready_in), 64'h2);
    chk("rm_after_empty",    64'(valid_out), 64'd0);
    @(negedge clk);
    valid_in = 4'b0000;
    #1;
    chk("rm_after_valid_out", 64'(valid_out), 64'd1);
    chk("rm_after_tag",       64'(tag_out),   64'd1);

    // Random traffic against an in-order scoreboard.
    for (int u = 0; u < 4; u++) begin
      u_vld[u] = 1'b0;
      u_seq[u] = '0;
      u_res[u] = '0;
      u_tag[u] = '0;
      u_hf[u]  = 1'b0;
      u_ff[u]  = '0;
    end
    acc = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        if (!u_vld[u] || acc[u]) begin
          u_vld[u] = ($urandom_range(0, 1) == 1);
          if (u_vld[u]) begin
            u_seq[u] = u_seq[u] + 24'd1;
            u_res[u] = {32'($urandom), 8'(u), u_seq[u]};
            u_tag[u] = 2'($urandom_range(0, 3));
            u_hf[u]  = ($urandom_range(0, 1) == 1);
            u_ff[u]  = 10'($urandom_range(0, 1023));
          end
        end
        valid_in[u]           = u_vld[u];
        result_in[u*64 +: 64] = u_res[u];
        tag_in[u*2 +: 2]      = u_tag[u];
        has_ff_in[u]          = u_hf[u];
        fflags_in[u*10 +: 10] = u_ff[u];
      end
      ready_out = ($urandom_range(0, 3) != 0);
      #1;
      acc = ready_in;
      if (!$onehot0(acc) || ((acc & ~valid_in) != 4'b0)) begin
        chk("rnd_grant_legal", 64'(acc), 64'(acc & valid_in));
      end
      if ((q.size() != 0) != valid_out) begin
        chk("rnd_valid_out", 64'(valid_out), 64'(q.size() != 0));
      end
      if (valid_out && ready_out) begin
        if (q.size() == 0) begin
          chk("rnd_pop_empty", 64'd1, 64'd0);
        end else begin
          h = q.pop_front();
          chk("rnd_result", result, h.res);
          chk("rnd_tag",    64'(tag_out), 64'(h.tag));
          chk("rnd_hasff",  64'(has_fflags), 64'(h.hf));
          chk("rnd_fflags", 64'(fflags), 64'(h.ff));
        end
      end
      for (int u = 0; u < 4; u++) begin
        if (acc[u]) begin
          e.res = u_res[u];
          e.tag = u_tag[u];
          e.hf  = u_hf[u];
          e.ff  = u_hf[u] ? u_ff[u] : 10'd0;
          q.push_back(e);
        end
      end
      if (q.size() > 2) begin
        chk("rnd_occupancy", 64'(q.size()), 64'd2);
      end
    end

    @(negedge clk);
    valid_in  = '0;
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("drain_pop_empty", 64'd1, 64'd0);
        end else begin
          h = q.pop_front();
          chk("drain_result", result, h.res);
        end
      end
      @(negedge clk);
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
    chk("drain_valid_out", 64'(valid_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
